// File: rtl/bnn_stream_loader_if.sv
// Stream-side and bank-side signals of the BNN serial loader, bundled as one port.
interface bnn_stream_loader_if #(
    parameter int IMG_H     = 28,
    parameter int IMG_W     = 28,
    parameter int K         = 3,
    parameter int NUM_FILT  = 8,
    parameter int PIX_LANES = 1
);
    logic                          en_wr;
    logic [PIX_LANES-1:0]          d_in_p;
    logic                          d_in_w;
    logic                          frame_start;
    logic                          weight_start;
    logic [IMG_H*IMG_W-1:0]        pixels;
    logic [NUM_FILT*K*K-1:0]       weights;
    logic                          pix_done;
    logic                          w_done;
    logic                          load_done;
    logic                          overrun;

    // Source of the bit streams and consumer of the banks.
    modport master (
        output en_wr, d_in_p, d_in_w, frame_start, weight_start,
        input  pixels, weights, pix_done, w_done, load_done, overrun
    );

    // The loader itself.
    modport slave (
        input  en_wr, d_in_p, d_in_w, frame_start, weight_start,
        output pixels, weights, pix_done, w_done, load_done, overrun
    );
endinterface

// File: rtl/bnn_stream_loader.sv
// Serial loader filling the BNN binary image and weight banks from asynchronous bit streams.
module bnn_stream_loader #(
    parameter int IMG_H       = 28,
    parameter int IMG_W       = 28,
    parameter int K           = 3,
    parameter int NUM_FILT    = 8,
    parameter int PIX_LANES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    bnn_stream_loader_if.slave bus
);
    localparam int NPIX   = IMG_H * IMG_W;
    localparam int NWGT   = NUM_FILT * K * K;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW     = (K > 1) ? $clog2(K) : 1;
    localparam int FW     = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int PIX_IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int W_IW   = (NWGT > 1) ? $clog2(NWGT) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - PIX_LANES);
    localparam logic [KW-1:0]    K_LAST   = KW'(K - 1);
    localparam logic [FW-1:0]    F_LAST   = FW'(NUM_FILT - 1);

    generate
        if (IMG_W % PIX_LANES != 0) begin : g_bad_lanes
            $error("bnn_stream_loader: IMG_W must be a multiple of PIX_LANES");
        end
        if (PIX_LANES != 1 && PIX_LANES != 2 && PIX_LANES != 4) begin : g_bad_lane_count
            $error("bnn_stream_loader: PIX_LANES must be 1, 2 or 4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("bnn_stream_loader: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0]                en_sync;
    logic [SYNC_STAGES-1:0]                w_sync;
    logic [SYNC_STAGES-1:0][PIX_LANES-1:0] p_sync;

    logic                 beat;
    logic [PIX_LANES-1:0] p_bit;
    logic                 w_bit;

    logic [NPIX-1:0]  pixels;
    logic [NWGT-1:0]  weights;
    logic [ROW_W-1:0] row, row_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic             pix_done, pix_done_nxt;
    logic [FW-1:0]    f, f_nxt;
    logic [KW-1:0]    t, t_nxt;
    logic [KW-1:0]    b, b_nxt;
    logic             w_done, w_done_nxt;
    logic             overrun;

    logic [PIX_IW-1:0] pix_base;
    logic [W_IW-1:0]   w_idx;

    // Multi-flop synchroniser for the asynchronous stream inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_sync <= '0;
            w_sync  <= '0;
            p_sync  <= '0;
        end else begin
            en_sync <= {en_sync[SYNC_STAGES-2:0], bus.en_wr};
            w_sync  <= {w_sync[SYNC_STAGES-2:0], bus.d_in_w};
            p_sync  <= {p_sync[SYNC_STAGES-2:0], bus.d_in_p};
        end
    end

    assign beat  = en_sync[SYNC_STAGES-1];
    assign p_bit = p_sync[SYNC_STAGES-1];
    assign w_bit = w_sync[SYNC_STAGES-1];

    assign pix_base = PIX_IW'(row) * PIX_IW'(IMG_W) + PIX_IW'(col);
    assign w_idx    = W_IW'(f) * W_IW'(K * K) + W_IW'(t) * W_IW'(K) + W_IW'(b);

    // Pixel cursor: restart on frame_start, else advance by one lane group per beat until full.
    always_comb begin
        row_nxt      = row;
        col_nxt      = col;
        pix_done_nxt = pix_done;
        if (bus.frame_start) begin
            row_nxt      = '0;
            col_nxt      = '0;
            pix_done_nxt = 1'b0;
        end else if (beat && !pix_done) begin
            if (col != COL_LAST) begin
                col_nxt = col + COL_W'(PIX_LANES);
            end else if (row != ROW_LAST) begin
                col_nxt = '0;
                row_nxt = row + ROW_W'(1);
            end else begin
                pix_done_nxt = 1'b1;
            end
        end
    end

    // Weight cursor: restart on weight_start, else b -> t -> f ripple per beat until full.
    always_comb begin
        f_nxt      = f;
        t_nxt      = t;
        b_nxt      = b;
        w_done_nxt = w_done;
        if (bus.weight_start) begin
            f_nxt      = '0;
            t_nxt      = '0;
            b_nxt      = '0;
            w_done_nxt = 1'b0;
        end else if (beat && !w_done) begin
            if (b != K_LAST) begin
                b_nxt = b + KW'(1);
            end else if (t != K_LAST) begin
                b_nxt = '0;
                t_nxt = t + KW'(1);
            end else if (f != F_LAST) begin
                b_nxt = '0;
                t_nxt = '0;
                f_nxt = f + FW'(1);
            end else begin
                w_done_nxt = 1'b1;
            end
        end
    end

    // Cursor and done-flag registers for both banks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row      <= '0;
            col      <= '0;
            pix_done <= 1'b0;
            f        <= '0;
            t        <= '0;
            b        <= '0;
            w_done   <= 1'b0;
        end else begin
            row      <= row_nxt;
            col      <= col_nxt;
            pix_done <= pix_done_nxt;
            f        <= f_nxt;
            t        <= t_nxt;
            b        <= b_nxt;
            w_done   <= w_done_nxt;
        end
    end

    // Pixel bank: frame_start wins over a coincident beat, whose pixel bits are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.frame_start) begin
            pixels <= '0;
        end else if (beat && !pix_done) begin
            for (int unsigned i = 0; i < PIX_LANES; i++) begin
                pixels[pix_base + PIX_IW'(i)] <= p_bit[i];
            end
        end
    end

    // Weight bank: weight_start wins over a coincident beat.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.weight_start) begin
            weights <= '0;
        end else if (beat && !w_done) begin
            weights[w_idx] <= w_bit;
        end
    end

    // Sticky flag for beats arriving when neither bank can take them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (beat && pix_done && w_done) begin
            overrun <= 1'b1;
        end
    end

    assign bus.pixels    = pixels;
    assign bus.weights   = weights;
    assign bus.pix_done  = pix_done;
    assign bus.w_done    = w_done;
    assign bus.load_done = pix_done & w_done;
    assign bus.overrun   = overrun;
endmodule
